// File: rtl/otter_cache.sv
// Direct-mapped, write-back, write-allocate cache between the OTTER CPU word bus
// and a line-wide backing-memory port. Hits answer combinationally in the request cycle.
module otter_cache #(
  parameter int LINE_BITS = 256,
  parameter int NUM_SETS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_byte_enable,
  output logic [31:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int WORDS  = LINE_BITS / 32;
  localparam int WORD_W = $clog2(WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
  typedef logic [WORDS-1:0][3:0][7:0] line_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  // Set and tag captured at the miss; the whole miss sequence works on these.
  logic [IDX_W-1:0]    miss_idx;
  logic [TAG_W-1:0]    miss_tag;
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [31:0]         pmem_address_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [WORD_W-1:0]   word;
  logic                lookup;
  logic                hit;
  logic                write_hit;
  logic                fill_done;
  line_t               line_merged;
  logic                unused_ok;

  assign idx  = mem_address[OFF_W +: IDX_W];
  assign tag  = mem_address[31 -: TAG_W];
  assign word = mem_address[2 +: WORD_W];
  assign unused_ok = ^mem_address[1:0];

  // A simultaneous read and write is illegal and simply never looks up.
  assign lookup    = !rst && (state == COMPARE) && (mem_read ^ mem_write);
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign write_hit = lookup && hit && mem_write;
  assign fill_done = !rst && (state == ALLOCATE) && pmem_resp;

  assign mem_resp     = lookup && hit;
  assign mem_rdata    = data_q[idx][word];
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = data_q[miss_idx];

  // NOTE: combinational blocks use blocking '=' and assign a full default first so no latch is inferred.
  always_comb begin
    line_merged = data_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (mem_byte_enable[i]) line_merged[word][i] = mem_wdata[8*i +: 8];
    end
  end

  // NOTE: tag/data are plain storage without reset; valid/dirty alone decide whether a line means anything.
  always_ff @(posedge clk) begin
    if (write_hit) data_q[idx] <= line_merged;
    if (fill_done) begin
      data_q[miss_idx] <= pmem_rdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= COMPARE;
      valid_q        <= '0;
      dirty_q        <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      unique case (state)
        COMPARE: begin
          if (write_hit) dirty_q[idx] <= 1'b1;
          if (lookup && !hit) begin
            miss_idx <= idx;
            miss_tag <= tag;
            if (valid_q[idx] && dirty_q[idx]) begin
              state          <= WRITEBACK;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_q[idx], idx, {OFF_W{1'b0}}};
            end else begin
              state          <= ALLOCATE;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty_q[miss_idx] <= 1'b0;
            state             <= ALLOCATE;
            pmem_write_q      <= 1'b0;
            pmem_read_q       <= 1'b1;
            pmem_address_q    <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= COMPARE;
            pmem_read_q       <= 1'b0;
            pmem_address_q    <= '0;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_cache.sv
// Self-checking bench for otter_cache: a CPU-visible memory model plus a backing-memory
// responder; expected read data is queued at request time and compared at mem_resp.
module tb_otter_cache;

  localparam int FILL_LAT = 3;
  localparam int BUDGET   = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  otter_cache #(.LINE_BITS(256), .NUM_SETS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] data;
  } sb_item_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } xfer_t;

  sb_item_t     sb_q[$];
  xfer_t        pmem_log[$];
  logic [255:0] bmem     [logic [31:0]];
  logic [31:0]  cpu_view [logic [31:0]];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_resp_edge = -1;
  int last_cpu_resp_cyc = -1;
  bit pmem_hold = 1'b0;

  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] bmem_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    int           w;
    wa = {a[31:2], 2'b00};
    if (cpu_view.exists(wa)) return cpu_view[wa];
    l = bmem_line({a[31:5], 5'b0});
    w = int'(a[4:2]);
    return l[32*w +: 32];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] cur;
    cur = model_read(a);
    for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = d[8*i +: 8];
    cpu_view[{a[31:2], 2'b00}] = cur;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = model_read(la + 32'(4*k));
    return l;
  endfunction

  function automatic string log_str();
    string s;
    s = "";
    foreach (pmem_log[i]) s = {s, $sformatf("%s%08h ", pmem_log[i].wr ? "W" : "R", pmem_log[i].addr)};
    return s;
  endfunction

  // ---------------- backing-memory responder ----------------
  initial begin : responder
    xfer_t x;
    bit    wr;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!pmem_hold && rst === 1'b0 && (pmem_read === 1'b1 || pmem_write === 1'b1)) begin
        wr = pmem_write;
        checks++;
        if (pmem_read === 1'b1 && pmem_write === 1'b1) begin
          errors++;
          $display("FAIL pmem_exclusive: read=%b write=%b, required never both", pmem_read, pmem_write);
        end
        x.wr = wr; x.addr = pmem_address; x.wdata = pmem_wdata;
        pmem_log.push_back(x);
        if (wr) begin
          checks++;
          if (pmem_wdata !== model_line(pmem_address)) begin
            errors++;
            $display("FAIL victim_line @%08h: got %h, required %h", pmem_address, pmem_wdata, model_line(pmem_address));
          end
          bmem[pmem_address] = pmem_wdata;
        end else begin
          pmem_rdata = bmem_line(pmem_address);
        end
        repeat (FILL_LAT - 1) @(negedge clk);
        pmem_resp = 1'b1;
        last_resp_edge = cyc + 1;
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if ((wr ? pmem_write : pmem_read) !== 1'b0) begin
          errors++;
          $display("FAIL pmem_drop: %s still %b after pmem_resp, required 0", wr ? "pmem_write" : "pmem_read",
                   wr ? pmem_write : pmem_read);
        end
      end
    end
  end

  // ---------------- CPU request driver ----------------
  task automatic cpu_access(input string name, input logic [31:0] addr, input bit wr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output int lat, output logic [31:0] rdata);
    sb_item_t it;
    sb_item_t expd;
    it.name    = name;
    it.is_read = !wr;
    it.data    = wr ? 32'h0 : model_read(addr);
    sb_q.push_back(it);
    if (wr) model_write(addr, wdata, be);
    @(posedge clk); #1;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_wdata = wdata; mem_byte_enable = be;
    lat = -1;
    rdata = 'x;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        lat = c;
        rdata = mem_rdata;
        last_cpu_resp_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    expd = sb_q.pop_front();
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s: no mem_resp within %0d cycles, required one", expd.name, BUDGET);
    end else if (expd.is_read && rdata !== expd.data) begin
      errors++;
      $display("FAIL %s: mem_rdata=%h, required %h", expd.name, rdata, expd.data);
    end
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0) begin
      errors++;
      $display("FAIL %s_single_resp: mem_resp=%b after completion, required 0", expd.name, mem_resp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: resp/rd/wr=%b%b%b addr=%h, required 000 and 0",
               mem_resp, pmem_read, pmem_write, pmem_address);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs: resp/rd/wr=%b%b%b addr=%h, required 000 and 0",
               mem_resp, pmem_read, pmem_write, pmem_address);
    end
  endtask

  task automatic test_read_miss();
    int           lat;
    logic [31:0]  rd;
    logic [255:0] l;
    l = bmem_line(32'h40);
    l[95:64] = 32'hDEADBEEF;
    bmem[32'h40] = l;
    pmem_log.delete();
    cpu_access("read_miss_48", 32'h48, 1'b0, '0, '0, lat, rd);
    checks++;
    if (log_str() != "R00000040 ") begin
      errors++; $display("FAIL read_miss_xfers: got \"%s\", required \"R00000040 \"", log_str());
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_miss_word: got %h, required deadbeef", rd);
    end
    checks++;
    if (last_cpu_resp_cyc != last_resp_edge) begin
      errors++; $display("FAIL read_miss_latency: resp after edge %0d, required edge %0d", last_cpu_resp_cyc, last_resp_edge);
    end
    pmem_log.delete();
    cpu_access("reread_48", 32'h48, 1'b0, '0, '0, lat, rd);
    checks++;
    if (lat != 0 || log_str() != "") begin
      errors++; $display("FAIL reread_hit: latency=%0d xfers=\"%s\", required 0 and none", lat, log_str());
    end
  endtask

  task automatic test_write_hit();
    int          lat;
    logic [31:0] rd;
    pmem_log.delete();
    cpu_access("write_hit_48", 32'h48, 1'b1, 32'h11223344, 4'b0011, lat, rd);
    checks++;
    if (lat != 0 || log_str() != "") begin
      errors++; $display("FAIL write_hit: latency=%0d xfers=\"%s\", required 0 and none", lat, log_str());
    end
    cpu_access("read_merged_48", 32'h48, 1'b0, '0, '0, lat, rd);
    checks++;
    if (rd !== 32'hDEAD3344 || lat != 0) begin
      errors++; $display("FAIL merged_word: got %h latency=%0d, required dead3344 latency 0", rd, lat);
    end
  endtask

  task automatic test_dirty_evict();
    int          lat;
    logic [31:0] rd;
    pmem_log.delete();
    cpu_access("read_evict_248", 32'h248, 1'b0, '0, '0, lat, rd);
    checks++;
    if (log_str() != "W00000040 R00000240 ") begin
      errors++; $display("FAIL evict_xfers: got \"%s\", required \"W00000040 R00000240 \"", log_str());
    end else begin
      checks++;
      if (pmem_log[0].wdata[95:64] !== 32'hDEAD3344) begin
        errors++; $display("FAIL evict_word2: got %h, required dead3344", pmem_log[0].wdata[95:64]);
      end
    end
  endtask

  task automatic test_zero_be();
    int          lat;
    logic [31:0] rd;
    pmem_log.delete();
    cpu_access("write_be0_244", 32'h244, 1'b1, 32'hFFFFFFFF, 4'b0000, lat, rd);
    cpu_access("read_be0_244", 32'h244, 1'b0, '0, '0, lat, rd);
    checks++;
    if (lat != 0 || log_str() != "") begin
      errors++; $display("FAIL be0_hit: latency=%0d xfers=\"%s\", required 0 and none", lat, log_str());
    end
    // The byte-enable-free write must still have marked the line dirty.
    cpu_access("read_back_48", 32'h48, 1'b0, '0, '0, lat, rd);
    checks++;
    if (log_str() != "W00000240 R00000040 ") begin
      errors++; $display("FAIL be0_dirty: got \"%s\", required \"W00000240 R00000040 \"", log_str());
    end
  endtask

  task automatic test_write_miss();
    int          lat;
    logic [31:0] rd;
    pmem_log.delete();
    cpu_access("write_miss_1004", 32'h1004, 1'b1, 32'hCAFEF00D, 4'b1111, lat, rd);
    checks++;
    if (log_str() != "R00001000 " || last_cpu_resp_cyc != last_resp_edge) begin
      errors++; $display("FAIL write_miss: xfers=\"%s\" resp edge %0d, required \"R00001000 \" edge %0d",
                         log_str(), last_cpu_resp_cyc, last_resp_edge);
    end
    for (int k = 0; k < 8; k++) begin
      cpu_access($sformatf("line_word_%0d", k), 32'h1000 + 32'(4*k), 1'b0, '0, '0, lat, rd);
      checks++;
      if (lat != 0) begin
        errors++; $display("FAIL line_word_%0d_hit: latency=%0d, required 0", k, lat);
      end
    end
  endtask

  task automatic test_illegal();
    int          lat;
    logic [31:0] rd;
    pmem_log.delete();
    @(posedge clk); #1;
    mem_address = 32'h1004; mem_read = 1'b1; mem_write = 1'b1;
    mem_wdata = 32'hFFFFFFFF; mem_byte_enable = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
        errors++; $display("FAIL illegal_cycle_%0d: resp/rd/wr=%b%b%b, required 000", c, mem_resp, pmem_read, pmem_write);
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    cpu_access("after_illegal_1004", 32'h1004, 1'b0, '0, '0, lat, rd);
    checks++;
    if (lat != 0 || log_str() != "") begin
      errors++; $display("FAIL after_illegal: latency=%0d xfers=\"%s\", required 0 and none", lat, log_str());
    end
  endtask

  task automatic test_reset_mid_fill();
    int          lat;
    logic [31:0] rd;
    bit          seen;
    pmem_hold = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    mem_address = 32'h60; mem_read = 1'b1; mem_write = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem_read === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || pmem_address !== 32'h60) begin
      errors++; $display("FAIL fill_start: seen=%0b addr=%h, required 1 and 00000060", seen, pmem_address);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== 32'h0) begin
      errors++; $display("FAIL reset_abort: rd/wr=%b%b addr=%h, required 00 and 0", pmem_read, pmem_write, pmem_address);
    end
    // Everything not yet written back is gone after reset.
    cpu_view.delete();
    pmem_hold = 1'b0;
    pmem_log.delete();
    cpu_access("post_reset_48", 32'h48, 1'b0, '0, '0, lat, rd);
    checks++;
    if (log_str() != "R00000040 " || rd !== 32'hDEAD3344) begin
      errors++; $display("FAIL post_reset_48: xfers=\"%s\" data=%h, required \"R00000040 \" dead3344", log_str(), rd);
    end
    pmem_log.delete();
    cpu_access("post_reset_1004", 32'h1004, 1'b0, '0, '0, lat, rd);
    checks++;
    if (log_str() != "R00001000 ") begin
      errors++; $display("FAIL post_reset_1004: xfers=\"%s\", required \"R00001000 \"", log_str());
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_zero_be();
    test_write_miss();
    test_illegal();
    test_reset_mid_fill();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
